rsa_key_sched: RTL and testbench

RSA_KEY_SCHED -- requirements
Module: rsa_key_sched

---
 rtl/rsa_pkg.sv | 38 +++
 rtl/rsa_cycle_cnt.sv | 37 +++
 rtl/rsa_key_sched.sv | 216 +++++++++++++++++++++
 tb/tb_rsa_key_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared widths, FSM state encoding, error codes and key payload for the RSA key scheduler.
package rsa_pkg;

    localparam int unsigned KEY_W   = 12;
    localparam int unsigned PRIME_W = 6;
    localparam int unsigned ERR_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_OPERAND = 2'd1;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

    // Captured key set presented to the consumer
    typedef struct packed {
        logic [KEY_W-1:0] n;
        logic [KEY_W-1:0] e;
        logic [KEY_W-1:0] d;
    } key_set_t;

    // Operand sanity: distinct primes >= 2 and 2 <= e < totient
    function automatic logic operands_bad(input logic [PRIME_W-1:0] p,
                                          input logic [PRIME_W-1:0] q,
                                          input logic [KEY_W-1:0]   e,
                                          input logic [KEY_W-1:0]   tot);
        return (p < PRIME_W'(2)) || (q < PRIME_W'(2)) || (p == q) ||
               (e < KEY_W'(2))   || (e >= tot);
    endfunction

endpackage

// File: rtl/rsa_cycle_cnt.sv
// Cycle counter shared by the SETTLE and WAIT phases: clear, enable, terminal-count compare.
module rsa_cycle_cnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == term_i);

endmodule

// File: rtl/rsa_key_sched.sv
// RSA key scheduler: derives n and totient from two primes, feeds an external
// private-key generator, waits for its result and hands out the key set.
// Optional feature macro: RSA_KEYSCHED_TIMEOUT_EN (abort WAIT after TIMEOUT_CYC cycles).
module rsa_key_sched
    import rsa_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 4095
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PRIME_W-1:0] p,
    input  logic [PRIME_W-1:0] q,
    input  logic [KEY_W-1:0]   e_in,
    output logic [KEY_W-1:0]   kg_e,
    output logic [KEY_W-1:0]   kg_totient,
    input  logic [KEY_W-1:0]   kg_d,
    input  logic               kg_flag,
    output logic [KEY_W-1:0]   n_out,
    output logic [KEY_W-1:0]   e_out,
    output logic [KEY_W-1:0]   d_out,
    output logic               key_valid,
    input  logic               key_ack,
    output logic               busy,
    output logic               err,
    output logic [ERR_W-1:0]   err_code
);

    localparam int unsigned SETTLE_TC = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
`ifdef RSA_KEYSCHED_TIMEOUT_EN
    localparam int unsigned TIMEOUT_TC = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int unsigned CNT_MAX    = (SETTLE_TC > TIMEOUT_TC) ? SETTLE_TC : TIMEOUT_TC;
`else
    localparam int unsigned CNT_MAX    = SETTLE_TC;
    // TIMEOUT_CYC has no effect when the timeout is compiled out
    if (TIMEOUT_CYC == 0) begin : g_timeout_unused
    end
`endif
    localparam int unsigned CNT_W = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    state_e state_q;
    state_e state_d;

    logic [PRIME_W-1:0] p_q;
    logic [PRIME_W-1:0] q_q;
    logic [KEY_W-1:0]   e_q;
    logic [KEY_W-1:0]   n_q;
    logic [KEY_W-1:0]   kg_e_q;
    logic [KEY_W-1:0]   kg_tot_q;
    key_set_t           key_q;
    logic               key_valid_q;
    logic               busy_q;
    logic               err_q;
    logic [ERR_W-1:0]   err_code_q;

    logic [KEY_W-1:0]   n_c;
    logic [KEY_W-1:0]   tot_c;
    logic               bad_c;

    logic               accept_c;
    logic               load_c;
    logic               capture_c;
    logic               cnt_clr_c;
    logic               cnt_en_c;
    logic [CNT_W-1:0]   cnt_term_c;
    logic               cnt_tc_c;
    logic               key_valid_d;
    logic               busy_d;
    logic               err_d;
    logic [ERR_W-1:0]   err_code_d;

    // Products of the registered primes, evaluated while in CALC
    always_comb begin
        n_c   = KEY_W'(p_q) * KEY_W'(q_q);
        tot_c = KEY_W'(p_q - PRIME_W'(1)) * KEY_W'(q_q - PRIME_W'(1));
        bad_c = operands_bad(p_q, q_q, e_q, tot_c);
    end

    // Shared SETTLE/WAIT cycle counter
    rsa_cycle_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (cnt_clr_c),
        .en_i   (cnt_en_c),
        .term_i (cnt_term_c),
        .tc_c_o (cnt_tc_c)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_CALC;
            ST_CALC:   state_d = bad_c ? ST_ERR : ST_LOAD;
            ST_LOAD:   state_d = (SETTLE_CYC == 0) ? ST_WAIT : ST_SETTLE;
            ST_SETTLE: if (cnt_tc_c) state_d = ST_WAIT;
            ST_WAIT: begin
                if (kg_flag) begin
                    state_d = ST_DONE;
                end
`ifdef RSA_KEYSCHED_TIMEOUT_EN
                else if (cnt_tc_c) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_DONE:   if (key_ack) state_d = ST_IDLE;
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM output decode: datapath strobes, counter control and next register values
    always_comb begin
        accept_c   = 1'b0;
        load_c     = 1'b0;
        capture_c  = 1'b0;
        cnt_clr_c  = 1'b0;
        cnt_en_c   = 1'b0;
        cnt_term_c = CNT_W'(SETTLE_TC);
        err_code_d = err_code_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    err_code_d = ERR_NONE;
                end
            end
            ST_CALC: begin
                if (bad_c) begin
                    err_code_d = ERR_OPERAND;
                end else begin
                    load_c = 1'b1;
                end
            end
            ST_LOAD: cnt_clr_c = 1'b1;
            ST_SETTLE: begin
                cnt_en_c = 1'b1;
                // restart the count so WAIT timing begins at zero
                if (cnt_tc_c) cnt_clr_c = 1'b1;
            end
            ST_WAIT: begin
                if (kg_flag) capture_c = 1'b1;
`ifdef RSA_KEYSCHED_TIMEOUT_EN
                cnt_en_c   = 1'b1;
                cnt_term_c = CNT_W'(TIMEOUT_TC);
                if (!kg_flag && cnt_tc_c) err_code_d = ERR_TIMEOUT;
`endif
            end
            default: ;
        endcase
        busy_d      = (state_d != ST_IDLE);
        key_valid_d = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
    end

    // Operand capture, keygen operand drive, key capture and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q         <= '0;
            q_q         <= '0;
            e_q         <= '0;
            n_q         <= '0;
            kg_e_q      <= '0;
            kg_tot_q    <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            if (accept_c) begin
                p_q <= p;
                q_q <= q;
                e_q <= e_in;
            end
            if (load_c) begin
                n_q      <= n_c;
                kg_e_q   <= e_q;
                kg_tot_q <= tot_c;
            end
            if (capture_c) begin
                key_q.n <= n_q;
                key_q.e <= e_q;
                key_q.d <= kg_d;
            end
            key_valid_q <= key_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign kg_e       = kg_e_q;
    assign kg_totient = kg_tot_q;
    assign n_out      = key_q.n;
    assign e_out      = key_q.e;
    assign d_out      = key_q.d;
    assign key_valid  = key_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_rsa_key_sched.sv
// Self-checking bench for rsa_key_sched: directed table, corner sequences, randomized jobs.
module tb_rsa_key_sched;

    localparam int S  = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n, start, kg_flag, key_ack;
    logic [5:0]  p, q;
    logic [11:0] e_in, kg_d;
    logic [11:0] kg_e, kg_totient, n_out, e_out, d_out;
    logic        key_valid, busy, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_kge = 0;
    int last_kgt = 0;

    always #5 clk = ~clk;

    rsa_key_sched #(
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .p          (p),
        .q          (q),
        .e_in       (e_in),
        .kg_e       (kg_e),
        .kg_totient (kg_totient),
        .kg_d       (kg_d),
        .kg_flag    (kg_flag),
        .n_out      (n_out),
        .e_out      (e_out),
        .d_out      (d_out),
        .key_valid  (key_valid),
        .key_ack    (key_ack),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code)
    );

    typedef struct {
        int p; int q; int e; int k; int d;
        bit bad; int n; int tot;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // reference arithmetic straight from the key-schedule rules
    function automatic void model(input int pp, input int qq, input int ee,
                                  output bit bad, output int n, output int tot);
        n   = pp * qq;
        tot = (pp - 1) * (qq - 1);
        bad = (pp < 2) || (qq < 2) || (pp == qq) || (ee < 2) || (ee >= tot);
    endfunction

    task automatic do_job(input string tag, input int pp, input int qq, input int ee,
                          input int k, input int dd, input bit stuck, input int ack_dly,
                          input bit ebad, input int en, input int etot);
        int exp_lat;
        p = 6'(pp); q = 6'(qq); e_in = 12'(ee); kg_d = 12'(dd);
        kg_flag = stuck; start = 1'b1; cyc = 0;
        for (int i = 0; i < 80 && !(key_valid || err); i++) begin
            tick();
            start = 1'b0;
            if (cyc == 1) begin
                p = ~p; q = ~q; e_in = ~e_in;
            end
            if (!stuck && !ebad && cyc == 2 + S + k) kg_flag = 1'b1;
        end
        if (ebad) begin
            chk($sformatf("%s err_cycle", tag), cyc, 2);
            chk($sformatf("%s err", tag), err, 1);
            chk($sformatf("%s err_code", tag), err_code, 1);
            chk($sformatf("%s kg_e_kept", tag), kg_e, last_kge);
            chk($sformatf("%s kg_tot_kept", tag), kg_totient, last_kgt);
            tick();
            chk($sformatf("%s err_drop", tag), {err, busy, key_valid}, 0);
            chk($sformatf("%s err_code_hold", tag), err_code, 1);
        end else begin
            exp_lat = 3 + S + (stuck ? 1 : k);
            chk($sformatf("%s latency", tag), cyc, exp_lat);
            chk($sformatf("%s key_valid", tag), key_valid, 1);
            chk($sformatf("%s n_out", tag), n_out, en);
            chk($sformatf("%s e_out", tag), e_out, ee);
            chk($sformatf("%s d_out", tag), d_out, dd);
            chk($sformatf("%s kg_e", tag), kg_e, ee);
            chk($sformatf("%s kg_totient", tag), kg_totient, etot);
            chk($sformatf("%s err_code", tag), {err, err_code, busy}, 1);
            last_kge = ee; last_kgt = etot;
            if (!stuck) kg_flag = 1'b0;
            kg_d = ~kg_d;
            for (int i = 0; i < ack_dly; i++) begin
                start = (i % 2 == 0);
                tick();
                chk($sformatf("%s hold%0d", tag, i), {key_valid, n_out, e_out, d_out},
                    {1'b1, 12'(en), 12'(ee), 12'(dd)});
            end
            key_ack = 1'b1; start = 1'b1;
            tick();
            key_ack = 1'b0; start = 1'b0;
            chk($sformatf("%s ack_idle", tag), {key_valid, busy}, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        bit   mb;
        int   mn, mt, rp, rq, re, rk, rd;
        int   lowc;

        tbl[0] = '{11, 13,   7, 5,  103, 1'b0,  143,  120};
        tbl[1] = '{11, 11,   7, 1,    0, 1'b1,    0,    0};
        tbl[2] = '{ 1, 13,   7, 1,    0, 1'b1,    0,    0};
        tbl[3] = '{11, 13,   1, 1,    0, 1'b1,    0,    0};
        tbl[4] = '{11, 13, 120, 1,    0, 1'b1,    0,    0};
        tbl[5] = '{11, 13, 119, 3,   77, 1'b0,  143,  120};
        tbl[6] = '{ 2,  3,   2, 1,    0, 1'b1,    0,    0};
        tbl[7] = '{ 3,  5,   3, 1,    3, 1'b0,   15,    8};
        tbl[8] = '{63, 61,   5, 4, 2233, 1'b0, 3843, 3720};
        tbl[9] = '{ 5,  7,   5, 2,    0, 1'b0,   35,   24};

        rst_n = 1'b0; start = 1'b0; kg_flag = 1'b0; key_ack = 1'b0;
        p = '0; q = '0; e_in = '0; kg_d = '0;
        tick(); tick();
        chk("reset status", {key_valid, busy, err, err_code}, 0);
        chk("reset kg", {kg_e, kg_totient}, 0);
        chk("reset key", {n_out, e_out, d_out}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_job($sformatf("vec%0d", i), tbl[i].p, tbl[i].q, tbl[i].e, tbl[i].k, tbl[i].d,
                   1'b0, (i == 0) ? 10 : i % 3, tbl[i].bad, tbl[i].n, tbl[i].tot);
            tick();
        end

        // flag left high from a previous job: must be ignored through SETTLE
        kg_flag = 1'b1;
        tick();
        do_job("stuck", 11, 13, 7, 5, 55, 1'b1, 1, 1'b0, 143, 120);
        kg_flag = 1'b0;
        tick();

        for (int i = 0; i < 25; i++) begin
            rp = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 63);
            rq = ($urandom_range(0, 7) == 0) ? rp : $urandom_range(2, 63);
            mn = (rp - 1) * (rq - 1);
            re = $urandom_range(0, (mn > 4) ? mn + 1 : 6);
            rk = $urandom_range(1, 6);
            rd = $urandom_range(0, 4095);
            model(rp, rq, re, mb, mn, mt);
            do_job($sformatf("rnd%0d", i), rp, rq, re, rk, rd, 1'b0,
                   $urandom_range(0, 3), mb, mn, mt);
            tick();
        end

        // reset while waiting for the keygen result
        p = 6'd11; q = 6'd13; e_in = 12'd7; start = 1'b1; cyc = 0;
        tick();
        start = 1'b0;
        while (cyc < 3 + S + 1) tick();
        chk("rst_wait busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_wait status", {key_valid, busy, err, err_code}, 0);
        chk("rst_wait outs", {kg_e, kg_totient, n_out, e_out, d_out}, 0);
        kg_flag = 1'b1;
        lowc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (key_valid || busy) lowc++;
        end
        chk("rst_wait no_valid", lowc, 0);
        kg_flag = 1'b0;
        last_kge = 0; last_kgt = 0;
        tick();

        // keygen never answers
        p = 6'd11; q = 6'd13; e_in = 12'd7; start = 1'b1; cyc = 0;
        tick();
        start = 1'b0;
`ifdef RSA_KEYSCHED_TIMEOUT_EN
        for (int i = 0; i < 80 && !err; i++) tick();
        chk("timeout cycle", cyc, 3 + S + TO);
        chk("timeout code", {err, err_code, key_valid}, {1'b1, 2'd2, 1'b0});
        tick();
        chk("timeout idle", {err, busy, err_code}, {1'b0, 1'b0, 2'd2});
`else
        lowc = 0;
        for (int i = 0; i < 3 + S + TO + 10; i++) begin
            tick();
            if (!busy || key_valid || err) lowc++;
        end
        chk("no_timeout busy", lowc, 0);
        chk("no_timeout code", err_code, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
